// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between execute (req0) and AGU (req1).
// Round-robin grant; define ALU_ARB_FIXED_PRIO_EN for fixed req0 priority.
//
// Ports:
//   clk, rst_n                  core clock, async active-low reset
//   reqN_valid/ready/a/b/op     requester N operation handshake (N=0,1)
//   alu_a, alu_b, alu_op        registered operands/opcode to the ALU
//   alu_c                       ALU result, valid ALU_LAT edges after launch
//   rsp_valid/ready/id/data     tagged response channel
//   busy                        FSM not in IDLE
module alu_arbiter #(
    parameter int ALU_LAT = 1,
    parameter int OP_W    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [31:0]     req0_a,
    input  logic [31:0]     req0_b,
    input  logic [OP_W-1:0] req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [31:0]     req1_a,
    input  logic [31:0]     req1_b,
    input  logic [OP_W-1:0] req1_op,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic [OP_W-1:0] alu_op,
    input  logic [31:0]     alu_c,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [31:0]     rsp_data,
    output logic            busy
);

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_alu_a;
    logic [31:0]       r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic [31:0]       r_rsp_data;
    logic              w_gnt1;
    logic              w_acc;
    logic              w_done;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // req1 only wins when req0 is idle.
    assign w_gnt1 = ~req0_valid;
`else
    logic r_last;

    // On contention, grant the requester that did not win last time.
    assign w_gnt1 = req1_valid & (~req0_valid | ~r_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_acc) begin
            r_last <= w_gnt1;
        end
    end
`endif

    assign w_acc  = req0_ready | req1_ready;
    assign w_done = (r_cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_acc) w_next = S_WAIT;
            S_WAIT: if (w_done) w_next = S_RESP;
            S_RESP: if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        busy       = 1'b1;
        if (r_state == S_IDLE) begin
            req0_ready = req0_valid & ~w_gnt1;
            req1_ready = req1_valid & w_gnt1;
            busy       = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_alu_a  <= w_gnt1 ? req1_a : req0_a;
                        r_alu_b  <= w_gnt1 ? req1_b : req0_b;
                        r_alu_op <= w_gnt1 ? req1_op : req0_op;
                        r_rsp_id <= w_gnt1;
                        r_cnt    <= '0;
                    end
                end
                S_WAIT: begin
                    if (w_done) begin
                        r_rsp_data  <= alu_c;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven + scoreboard bench for alu_arbiter.
// Instance 0 uses ALU_LAT=1, instance 1 uses ALU_LAT=3.
module tb_alu_arbiter;

    typedef struct {
        bit          v0;
        bit          v1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [3:0]  op;
        bit          hold;
        int          rwait;
        bit          eid;
        logic [31:0] edata;
    } vec_t;

    typedef struct {
        bit          id;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        r0v[2];
    logic        r1v[2];
    logic        r0rdy[2];
    logic        r1rdy[2];
    logic [31:0] r0a[2];
    logic [31:0] r0b[2];
    logic [31:0] r1a[2];
    logic [31:0] r1b[2];
    logic [3:0]  r0o[2];
    logic [3:0]  r1o[2];
    logic [31:0] aa[2];
    logic [31:0] ab[2];
    logic [3:0]  aop[2];
    logic        rv[2];
    logic        rr[2];
    logic        rid[2];
    logic [31:0] rdat[2];
    logic        bsy[2];
    logic [31:0] ac0;
    logic [31:0] ac1;
    logic [31:0] p1;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t tbl[9];

    function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b,
                                          logic [3:0] op);
        return (op == 4'h0) ? a + b : a ^ b;
    endfunction

    assign ac0 = alu_f(aa[0], ab[0], aop[0]);

    always_ff @(posedge clk) begin
        p1  <= alu_f(aa[1], ab[1], aop[1]);
        ac1 <= p1;
    end

    alu_arbiter #(.ALU_LAT(1), .OP_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v[0]), .req0_ready(r0rdy[0]),
        .req0_a(r0a[0]), .req0_b(r0b[0]), .req0_op(r0o[0]),
        .req1_valid(r1v[0]), .req1_ready(r1rdy[0]),
        .req1_a(r1a[0]), .req1_b(r1b[0]), .req1_op(r1o[0]),
        .alu_a(aa[0]), .alu_b(ab[0]), .alu_op(aop[0]), .alu_c(ac0),
        .rsp_valid(rv[0]), .rsp_ready(rr[0]), .rsp_id(rid[0]),
        .rsp_data(rdat[0]), .busy(bsy[0])
    );

    alu_arbiter #(.ALU_LAT(3), .OP_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v[1]), .req0_ready(r0rdy[1]),
        .req0_a(r0a[1]), .req0_b(r0b[1]), .req0_op(r0o[1]),
        .req1_valid(r1v[1]), .req1_ready(r1rdy[1]),
        .req1_a(r1a[1]), .req1_b(r1b[1]), .req1_op(r1o[1]),
        .alu_a(aa[1]), .alu_b(ab[1]), .alu_op(aop[1]), .alu_c(ac1),
        .rsp_valid(rv[1]), .rsp_ready(rr[1]), .rsp_id(rid[1]),
        .rsp_data(rdat[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input int d, input string nm);
        chk({nm, ".rsp_valid"}, 32'(rv[d]), 32'd0);
        chk({nm, ".rsp_id"}, 32'(rid[d]), 32'd0);
        chk({nm, ".rsp_data"}, rdat[d], 32'd0);
        chk({nm, ".alu_a"}, aa[d], 32'd0);
        chk({nm, ".alu_b"}, ab[d], 32'd0);
        chk({nm, ".alu_op"}, 32'(aop[d]), 32'd0);
        chk({nm, ".busy"}, 32'(bsy[d]), 32'd0);
    endtask

    task automatic run_op(input int d, input vec_t v, input string nm);
        exp_t        e;
        int          lat;
        int          want_lat;
        logic [31:0] ea;
        logic [31:0] eb;
        want_lat = (d == 0) ? 1 : 3;
        @(negedge clk);
        r0v[d] = v.v0;
        r1v[d] = v.v1;
        r0a[d] = v.a0;
        r0b[d] = v.b0;
        r0o[d] = v.op;
        r1a[d] = v.a1;
        r1b[d] = v.b1;
        r1o[d] = v.op;
        rr[d]  = (v.rwait == 0);
        #1;
        chk({nm, ".req0_ready"}, 32'(r0rdy[d]), 32'(v.v0 && !v.eid));
        chk({nm, ".req1_ready"}, 32'(r1rdy[d]), 32'(v.v1 && v.eid));
        sb.push_back('{v.eid, v.edata});
        ea = v.eid ? v.a1 : v.a0;
        eb = v.eid ? v.b1 : v.b0;
        @(posedge clk);
        #1;
        if (!v.hold) begin
            r0v[d] = 1'b0;
            r1v[d] = 1'b0;
        end
        chk({nm, ".alu_a"}, aa[d], ea);
        chk({nm, ".alu_b"}, ab[d], eb);
        chk({nm, ".alu_op"}, 32'(aop[d]), 32'(v.op));
        chk({nm, ".busy"}, 32'(bsy[d]), 32'd1);
        lat = 0;
        for (int k = 0; k < 20 && !rv[d]; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (!rv[d]) begin
                chk({nm, ".wait_alu_a"}, aa[d], ea);
                chk({nm, ".wait_alu_b"}, ab[d], eb);
                chk({nm, ".wait_rdy"}, 32'(r0rdy[d] | r1rdy[d]), 32'd0);
            end
        end
        chk({nm, ".rsp_valid"}, 32'(rv[d]), 32'd1);
        chk({nm, ".latency"}, 32'(lat), 32'(want_lat));
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s.scoreboard: got empty queue expected entry", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, ".rsp_id"}, 32'(rid[d]), 32'(e.id));
            chk({nm, ".rsp_data"}, rdat[d], e.data);
        end
        for (int k = 0; k < v.rwait; k++) begin
            @(posedge clk);
            #1;
            chk({nm, ".bp_valid"}, 32'(rv[d]), 32'd1);
            chk({nm, ".bp_id"}, 32'(rid[d]), 32'(v.eid));
            chk({nm, ".bp_data"}, rdat[d], v.edata);
            chk({nm, ".bp_rdy"}, 32'(r0rdy[d] | r1rdy[d]), 32'd0);
        end
        if (v.rwait > 0) begin
            @(negedge clk);
            rr[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({nm, ".done_valid"}, 32'(rv[d]), 32'd0);
        chk({nm, ".done_busy"}, 32'(bsy[d]), 32'd0);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            r0v[d] = 1'b0;
            r1v[d] = 1'b0;
            r0a[d] = '0;
            r0b[d] = '0;
            r1a[d] = '0;
            r1b[d] = '0;
            r0o[d] = '0;
            r1o[d] = '0;
            rr[d]  = 1'b1;
        end

        tbl[0] = '{1, 0, 32'd5, 32'd7, 32'd0, 32'd0, 4'h0, 0, 0,
                   0, 32'd12};
        tbl[1] = '{0, 1, 32'd0, 32'd0, 32'd100, 32'd23, 4'h0, 0, 0,
                   1, 32'd123};
`ifdef ALU_ARB_FIXED_PRIO_EN
        tbl[2] = '{1, 1, 32'd1, 32'd2, 32'd10, 32'd20, 4'h0, 1, 0, 0, 32'd3};
        tbl[3] = '{1, 1, 32'd1, 32'd2, 32'd10, 32'd20, 4'h0, 1, 0, 0, 32'd3};
        tbl[4] = '{1, 1, 32'd1, 32'd2, 32'd10, 32'd20, 4'h0, 1, 0, 0, 32'd3};
        tbl[5] = '{1, 1, 32'd1, 32'd2, 32'd10, 32'd20, 4'h0, 1, 0, 0, 32'd3};
`else
        tbl[2] = '{1, 1, 32'd1, 32'd2, 32'd10, 32'd20, 4'h0, 1, 0, 0, 32'd3};
        tbl[3] = '{1, 1, 32'd1, 32'd2, 32'd10, 32'd20, 4'h0, 1, 0, 1, 32'd30};
        tbl[4] = '{1, 1, 32'd1, 32'd2, 32'd10, 32'd20, 4'h0, 1, 0, 0, 32'd3};
        tbl[5] = '{1, 1, 32'd1, 32'd2, 32'd10, 32'd20, 4'h0, 1, 0, 1, 32'd30};
`endif
        tbl[6] = '{1, 0, 32'h1234, 32'h1, 32'd0, 32'd0, 4'h0, 1, 5,
                   0, 32'h1235};
        tbl[7] = '{0, 1, 32'd0, 32'd0, 32'hF0F0, 32'h0FF0, 4'h3, 0, 0,
                   1, 32'hFF00};
        tbl[8] = '{1, 0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 4'h0,
                   0, 0, 0, 32'h0};

        #1;
        chk_reset(0, "por0");
        chk_reset(1, "por1");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(0, tbl[i], $sformatf("vec%0d", i));
        end

        run_op(1, '{0, 1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 4'h0, 0, 0,
                    1, 32'd0}, "lat3_wrap");
        run_op(1, '{1, 0, 32'd20, 32'd22, 32'd0, 32'd0, 4'h0, 0, 0,
                    0, 32'd42}, "lat3_op");

        @(negedge clk);
        r1v[1] = 1'b1;
        r1a[1] = 32'd3;
        r1b[1] = 32'd4;
        r1o[1] = 4'h0;
        @(posedge clk);
        #1;
        r1v[1] = 1'b0;
        chk("mid.busy", 32'(bsy[1]), 32'd1);
        chk("mid.alu_a", aa[1], 32'd3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset(1, "mid_rst1");
        chk_reset(0, "mid_rst0");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (rv[1]) seen = 1'b1;
        end
        chk("mid.no_rsp", 32'(seen), 32'd0);

        run_op(1, '{1, 1, 32'd6, 32'd9, 32'd50, 32'd60, 4'h0, 0, 0,
                    0, 32'd15}, "post_rst_contend");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
